pa_perips_intc: RTL and testbench
=================================

// Module: pa_perips_intc
// PURPOSE
//  Machine-level external interrupt controller. It is the source side of the core interrupt line: it drives the
//  irq_o edge that the core interrupt unit samples (2-flop sync, rising-edge detect). It collects IRQ_NUM peripheral
//  sources, latches rising edges as pending, masks them with an enable register and arbitrates by fixed priority
//  (index 0 highest). Software uses claim/complete over the peripheral register bus.
// PARAMETERS
//  IRQ_NUM     8   number of interrupt sources, 1..31
//  GAP_CYCLES  2   minimum irq_o low cycles between two assertions, >=1
// PORTS
//  clk_i       in   1        core clock
//  rst_i       in   1        synchronous reset, active-high
//  src_irq_i   in   IRQ_NUM  raw peripheral interrupt levels, asynchronous to clk_i
//  addr_i      in   8        byte address of register; [1:0] ignored
//  wr_en_i     in   1        write strobe, single cycle
//  rd_en_i     in   1        read strobe, single cycle
//  wdata_i     in   32       write data
//  rdata_o     out  32       read data, valid 1 cycle after rd_en_i
//  irq_o       out  1        interrupt request to core
// BEHAVIOUR
//  Reset (rst_i=1 at clk edge): all outputs 0. PENDING, ENABLE, sync flops, claim_id, gap counter cleared.
//   FSM returns to S_IDLE. Reset applies mid-operation, including in S_ASSERT, with no other priority.
//  Source path: 2-flop sync per source. A 0->1 on the synced level sets PENDING[n] on the next edge.
//   Levels held high do not re-set PENDING.
//  Registers:
//   0x00 PENDING  RO; write-1-to-clear. Edge-set and w1c on the same bit in the same cycle: set wins.
//   0x04 ENABLE   RW, bits [IRQ_NUM-1:0]; upper bits read 0.
//   0x08 CLAIM    read returns id = n+1 for lowest n with PENDING[n]&ENABLE[n], else 0.
//                 A nonzero read clears PENDING[n] and loads claim_id=id. Read-side effect occurs only in S_ASSERT;
//                 in other states the read returns 0 with no side effect.
//   0x0C COMPLETE write id. Accepted only in S_BUSY with wdata_i[4:0]==claim_id; otherwise ignored.
//   Unmapped addresses: read 0, write ignored.
//  rdata_o is registered; 1-cycle latency. It holds its last value when rd_en_i=0.
//   rd_en_i and wr_en_i asserted together: write performed, read returns pre-write value.
//  FSM (irq_o registered, asserted only in S_ASSERT):
//   S_IDLE   : if |(PENDING&ENABLE) -> S_ASSERT
//   S_ASSERT : irq_o=1. Nonzero CLAIM read -> S_BUSY.
//              If enabled-pending drops to 0 (w1c or ENABLE cleared) -> S_GAP.
//   S_BUSY   : irq_o=0. Accepted COMPLETE -> S_GAP (cnt=GAP_CYCLES-1).
//   S_GAP    : irq_o=0. Counter decrements each cycle; at 0 -> S_IDLE.
//  irq_o stays low >= GAP_CYCLES cycles between assertions, so the core edge detector sees every new request.
//  Only one interrupt in service at a time; other sources stay pending until complete.
//  Width rules: id is 5 bits, zero-extended to 32 on rdata_o. Priority encoder is purely combinational.
// STRUCTURE
//  Shared package/header (pa_chip_param.v): INTC_PENDING/ENABLE/CLAIM/COMPLETE offsets, FSM state encodings.
//  Sub-module pa_perips_intc_sync: IRQ_NUM-wide 2-flop synchronizer plus rising-edge detect.
//  Priority encoder and FSM stay inline.
// TESTING
//  1. ENABLE=0x05, pulse src[2] -> PENDING=0x04 after 3 clks, irq_o=1 1 clk later. CLAIM read=3, irq_o=0.
//     Write COMPLETE=3 -> irq_o low >=2 cycles, stays low.
//  2. src[1] and src[4] rise together, ENABLE=0x12 -> CLAIM=2. Complete, then after the gap irq_o re-asserts;
//     CLAIM=5.
//  3. Write COMPLETE=4 while claim_id=2 -> ignored, FSM stays S_BUSY. COMPLETE=2 -> S_GAP.
//  4. In S_ASSERT, write PENDING=0x04 (w1c) with src[2] only -> irq_o drops, GAP, IDLE.
//     Same-cycle edge plus w1c on bit 2 -> bit stays set.
//  5. CLAIM read in S_IDLE -> rdata_o=0, PENDING unchanged. Unmapped 0x40 read -> 0.
//  6. Assert rst_i in S_BUSY -> next clk: irq_o=0, PENDING=0, ENABLE=0, rdata_o=0, FSM S_IDLE.

Source files
------------

// File: rtl/pa_perips_intc_pkg.sv
// Shared register word offsets and FSM state encoding for the external interrupt controller.
package pa_perips_intc_pkg;

  // Word indices (byte address [7:2]) of the register map
  localparam logic [5:0] INTC_PENDING  = 6'h00;
  localparam logic [5:0] INTC_ENABLE   = 6'h01;
  localparam logic [5:0] INTC_CLAIM    = 6'h02;
  localparam logic [5:0] INTC_COMPLETE = 6'h03;

  localparam int ID_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_BUSY   = 2'd2,
    S_GAP    = 2'd3
  } intc_state_e;

endpackage

// File: rtl/pa_perips_intc_sync.sv
// Per-source 2-flop synchronizer followed by a rising-edge detector on the synced level.
module pa_perips_intc_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      meta_reg <= level;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
    assign rise[gi] = sync_reg[gi] & ~prev_reg[gi];
  end

endmodule

// File: rtl/pa_perips_intc.sv
// Machine external interrupt controller: edge-latched pending, enable mask, fixed priority,
// claim/complete handshake and a guaranteed low gap on irq_o between requests.
module pa_perips_intc
  import pa_perips_intc_pkg::*;
#(
  parameter int IRQ_NUM    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] src_irq_i,
  input  logic [7:0]         addr_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               irq_o
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] pending_reg;
  logic [IRQ_NUM-1:0] enable_reg;
  logic [IRQ_NUM-1:0] active;
  logic [IRQ_NUM-1:0] w1c_mask;
  logic [IRQ_NUM-1:0] claim_clr;
  logic [ID_W-1:0]    id;
  logic [ID_W-1:0]    claim_id_reg;
  logic [CNT_W-1:0]   gap_reg;
  intc_state_e        state_reg;
  logic               irq_reg;
  logic [31:0]        rdata_reg;
  logic [31:0]        rdata_next;
  logic [5:0]         word;
  logic               claim_take;
  logic               complete_ok;
  logic               unused_bits;

  pa_perips_intc_sync #(.WIDTH(IRQ_NUM)) u_sync (
    .clk   (clk_i),
    .rst   (rst_i),
    .level (src_irq_i),
    .rise  (rise)
  );

  assign word        = addr_i[7:2];
  assign active      = pending_reg & enable_reg;
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:IRQ_NUM]};

  // Lowest index wins: scan downward so the last hit is the highest-priority source
  always_comb begin
    id = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (active[i]) id = ID_W'(i + 1);
    end
  end

  assign claim_take  = rd_en_i && (word == INTC_CLAIM) && (state_reg == S_ASSERT) && (id != '0);
  assign complete_ok = wr_en_i && (word == INTC_COMPLETE) && (state_reg == S_BUSY) &&
                       (wdata_i[ID_W-1:0] == claim_id_reg);
  assign w1c_mask    = (wr_en_i && (word == INTC_PENDING)) ? wdata_i[IRQ_NUM-1:0] : '0;

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      claim_clr[i] = claim_take && (id == ID_W'(i + 1));
    end
  end

  always_comb begin
    rdata_next = rdata_reg;
    if (rd_en_i) begin
      case (word)
        INTC_PENDING: rdata_next = 32'(pending_reg);
        INTC_ENABLE:  rdata_next = 32'(enable_reg);
        INTC_CLAIM:   rdata_next = (state_reg == S_ASSERT) ? 32'(id) : 32'd0;
        default:      rdata_next = 32'd0;
      endcase
    end
  end

  // New edges are ORed in last so a same-cycle set beats any clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg  <= '0;
      enable_reg   <= '0;
      claim_id_reg <= '0;
      rdata_reg    <= '0;
    end else begin
      pending_reg <= (pending_reg & ~w1c_mask & ~claim_clr) | rise;
      rdata_reg   <= rdata_next;
      if (wr_en_i && (word == INTC_ENABLE)) enable_reg <= wdata_i[IRQ_NUM-1:0];
      if (claim_take) claim_id_reg <= id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      gap_reg   <= '0;
      irq_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|active) begin
            state_reg <= S_ASSERT;
            irq_reg   <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (claim_take) begin
            state_reg <= S_BUSY;
            irq_reg   <= 1'b0;
          end else if (!(|active)) begin
            state_reg <= S_GAP;
            gap_reg   <= GAP_LOAD;
            irq_reg   <= 1'b0;
          end
        end
        S_BUSY: begin
          if (complete_ok) begin
            state_reg <= S_GAP;
            gap_reg   <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (gap_reg == '0) state_reg <= S_IDLE;
          else               gap_reg   <= gap_reg - 1'b1;
        end
        default: begin
          state_reg <= S_IDLE;
          irq_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_o = rdata_reg;
  assign irq_o   = irq_reg;

endmodule

// File: tb/tb_pa_perips_intc.sv
// Scoreboard bench for pa_perips_intc: directed scenarios plus random traffic against a behavioural model.
module tb_pa_perips_intc;

  localparam int N = 8;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src = '0;
  logic [7:0]   addr = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         irq;

  pa_perips_intc #(.IRQ_NUM(N), .GAP_CYCLES(G)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .src_irq_i (src),
    .addr_i    (addr),
    .wr_en_i   (wr_en),
    .rd_en_i   (rd_en),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] v;
  } rd_t;

  rd_t sb[$];
  int  checks = 0;
  int  fails  = 0;

  // Behavioural model: src history, pending/enable sets, and a service phase
  typedef enum {P_IDLE, P_REQ, P_SERV, P_QUIET} phase_t;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_en   = '0;
  logic [N-1:0] hist [3];
  phase_t       m_phase = P_IDLE;
  logic [4:0]   m_claim = '0;
  int           m_quiet = 0;
  logic         exp_irq = 1'b0;

  task automatic model_step();
    logic [N-1:0] rise_v, act, clr, new_en;
    logic [31:0]  v;
    logic [5:0]   w;
    int           low;
    bit           took, done;
    phase_t       nxt;
    if (rst) begin
      m_pend = '0; m_en = '0; m_phase = P_IDLE; m_claim = '0; m_quiet = 0; exp_irq = 1'b0;
      for (int k = 0; k < 3; k++) hist[k] = '0;
      sb.push_back('{8'hFF, 32'd0});
      return;
    end
    rise_v = hist[1] & ~hist[2];
    act    = m_pend & m_en;
    low    = -1;
    for (int i = N - 1; i >= 0; i--) if (act[i]) low = i;
    w = addr[7:2];
    clr = '0; new_en = m_en; took = 0; done = 0;
    if (rd_en) begin
      v = 32'd0;
      if (w == 6'd0) v = 32'(m_pend);
      else if (w == 6'd1) v = 32'(m_en);
      else if (w == 6'd2 && m_phase == P_REQ && low >= 0) begin
        v = 32'(low + 1);
        took = 1;
        clr[low] = 1'b1;
      end
      sb.push_back('{addr, v});
    end
    if (wr_en) begin
      if (w == 6'd0) clr = clr | wdata[N-1:0];
      else if (w == 6'd1) new_en = wdata[N-1:0];
      else if (w == 6'd3) done = (m_phase == P_SERV) && (wdata[4:0] == m_claim);
    end
    nxt = m_phase;
    case (m_phase)
      P_IDLE:  if (low >= 0) nxt = P_REQ;
      P_REQ: begin
        if (took) begin nxt = P_SERV; m_claim = 5'(low + 1); end
        else if (low < 0) begin nxt = P_QUIET; m_quiet = G - 1; end
      end
      P_SERV:  if (done) begin nxt = P_QUIET; m_quiet = G - 1; end
      P_QUIET: if (m_quiet == 0) nxt = P_IDLE; else m_quiet--;
      default: nxt = P_IDLE;
    endcase
    m_pend  = (m_pend & ~clr) | rise_v;
    m_en    = new_en;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = src;
    m_phase = nxt;
    exp_irq = (nxt == P_REQ);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) hist[k] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: read data is presented the cycle after each strobe; irq checked every cycle
  initial begin
    rd_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdata !== e.v) begin
          fails++;
          $display("FAIL rdata addr=%02h got=%08h exp=%08h t=%0t", e.a, rdata, e.v, $time);
        end else begin
          $display("read addr=%02h data=%08h t=%0t", e.a, rdata, $time);
        end
      end
      checks++;
      if (irq !== exp_irq) begin
        fails++;
        $display("FAIL irq got=%b exp=%b t=%0t", irq, exp_irq, $time);
      end
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
    rd_en = rd; wr_en = wr; addr = a; wdata = d;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [31:0] rd_d;
    int          pick;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op(1, 0, 8'h00, 32'h0);
    op(1, 0, 8'h04, 32'h0);

    // Single source, claim and complete
    op(0, 1, 8'h04, 32'h05);
    src[2] = 1'b1; idle(2); src[2] = 1'b0; idle(4);
    op(1, 0, 8'h00, 32'h0);
    op(1, 0, 8'h08, 32'h0);
    idle(1);
    op(0, 1, 8'h0C, 32'd3);
    idle(6);

    // Two simultaneous sources, wrong then right complete
    op(0, 1, 8'h04, 32'h12);
    src = 8'h12; idle(5);
    op(1, 0, 8'h08, 32'h0);
    src = 8'h00;
    op(0, 1, 8'h0C, 32'd4);
    idle(2);
    op(0, 1, 8'h0C, 32'd2);
    idle(5);
    op(1, 0, 8'h08, 32'h0);
    op(0, 1, 8'h0C, 32'd5);
    idle(5);

    // w1c while asserted, then edge coinciding with w1c
    op(0, 1, 8'h04, 32'h04);
    src[2] = 1'b1; idle(5);
    op(0, 1, 8'h00, 32'h04);
    idle(5);
    src[2] = 1'b0; idle(2);
    src[2] = 1'b1; idle(2);
    op(0, 1, 8'h00, 32'h04);
    op(1, 0, 8'h00, 32'h0);
    op(1, 0, 8'h08, 32'h0);
    op(0, 1, 8'h0C, 32'd3);
    idle(4);

    // Claim outside S_ASSERT, unmapped read, simultaneous read/write
    op(1, 0, 8'h08, 32'h0);
    op(1, 0, 8'h40, 32'h0);
    op(1, 1, 8'h04, 32'hFF);
    op(1, 0, 8'h04, 32'h0);

    // Reset while busy
    src[0] = 1'b1; idle(5);
    op(1, 0, 8'h08, 32'h0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    op(1, 0, 8'h00, 32'h0);
    op(1, 0, 8'h04, 32'h0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) src = src ^ N'(1 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        pick = $urandom_range(0, 4);
        ra = (pick == 4) ? 8'h40 : 8'(pick * 4);
        rd_d = $urandom;
        if (pick == 3) rd_d = ($urandom_range(0, 1) == 1) ? 32'(m_claim) : 32'($urandom_range(0, 9));
        op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rd_d);
      end else begin
        idle(1);
      end
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
